// File: rtl/trng_uart_pkg.sv
// Shared definitions for the TRNG FIFO_OUT -> UART drain path: frame
// constants, serializer state encoding and the baud divisor computation.
package trng_uart_pkg;

    // Serializer states; IDLE must stay 0 so a cleared register is idle.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

    // 8N1 framing, four bytes per 32-bit TRNG word.
    localparam int unsigned DATA_BITS      = 8;
    localparam int unsigned STOP_BITS      = 1;
    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned WORD_W         = DATA_BITS * BYTES_PER_WORD;
    localparam int unsigned COUNT_W        = 16;
    localparam int unsigned BYTE_IDX_W     = $clog2(BYTES_PER_WORD);
    localparam int unsigned BIT_CNT_W      = $clog2(DATA_BITS);

    // Cycles per UART bit (truncating divide); callers need a result >= 4.
    function automatic int unsigned calc_clks_per_bit(input int unsigned clk_freq,
                                                      input int unsigned baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer.
// Ports:
//   clk, rst   - clock, asynchronous active-low reset
//   start      - accept data (in IDLE, or on the last cycle of STOP for
//                gap-free chaining of bytes)
//   data[7:0]  - byte to send, sampled when start is accepted
//   done       - combinational: high on the final cycle of the stop bit
//   tx         - registered serial output, idle high
module uart_tx_byte
    import trng_uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [DATA_BITS-1:0] data,
    output logic                 done,
    output logic                 tx
);

    localparam int unsigned               BAUD_W    = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0]         BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_CNT_W-1:0]      BIT_LAST  = BIT_CNT_W'(DATA_BITS - 1);

    uart_state_e            state_q, state_d;
    logic [BAUD_W-1:0]      baud_cnt_q, baud_cnt_d;
    logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0]   data_q, data_d;
    logic                   tx_q, tx_d;
    logic                   bit_end_c;
    logic                   done_c;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            data_q     <= '0;
            tx_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            data_q     <= data_d;
            tx_q       <= tx_d;
        end
    end

    // Next-state and line-level logic.
    always_comb begin
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        data_d     = data_q;
        done_c     = 1'b0;
        tx_d       = 1'b1;
        bit_end_c  = (baud_cnt_q == BAUD_LAST);

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_START;
                    baud_cnt_d = '0;
                    bit_cnt_d  = '0;
                    data_d     = data;
                end
            end
            ST_START: begin
                if (bit_end_c) begin
                    state_d    = ST_DATA;
                    baud_cnt_d = '0;
                    bit_cnt_d  = '0;
                end else begin
                    baud_cnt_d = baud_cnt_q + 1'b1;
                end
            end
            ST_DATA: begin
                if (bit_end_c) begin
                    baud_cnt_d = '0;
                    if (bit_cnt_q == BIT_LAST) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + 1'b1;
                end
            end
            ST_STOP: begin
                if (bit_end_c) begin
                    done_c     = 1'b1;
                    baud_cnt_d = '0;
                    bit_cnt_d  = '0;
                    // Restart straight from STOP so bytes of a word abut.
                    if (start) begin
                        state_d = ST_START;
                        data_d  = data;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Line level is registered off the next state so tx never glitches.
        unique case (state_d)
            ST_START: tx_d = 1'b0;
            ST_DATA:  tx_d = data_d[bit_cnt_d];
            default:  tx_d = 1'b1;
        endcase
    end

    assign done = done_c;
    assign tx   = tx_q;

endmodule

// File: rtl/fifo_uart_tx.sv
// Drains 32-bit TRNG words from first-word-fall-through FIFO_OUT and sends
// each as four 8N1 UART frames, least-significant byte first.
// Ports:
//   clk, rst      - clock, asynchronous active-low reset
//   enable        - drain permission, sampled only between words
//   fifo_empty    - FIFO_OUT empty flag, sampled only between words
//   fifo_rd_data  - FIFO_OUT head word
//   fifo_rd_en    - one-cycle pop strobe, one per word
//   uart_tx       - serial line, idle high
//   busy          - high while a word is being sent
//   words_sent    - wrapping count of completed words
module fifo_uart_tx
    import trng_uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 100_000_000,
    parameter int unsigned BAUD     = 115_200
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic               fifo_empty,
    input  logic [WORD_W-1:0]  fifo_rd_data,
    output logic               fifo_rd_en,
    output logic               uart_tx,
    output logic               busy,
    output logic [COUNT_W-1:0] words_sent
);

    localparam int unsigned             CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ, BAUD);
    localparam logic [BYTE_IDX_W-1:0]   BYTE_LAST    = BYTE_IDX_W'(BYTES_PER_WORD - 1);

    logic [WORD_W-1:0]     word_q, word_d;
    logic [BYTE_IDX_W-1:0] byte_idx_q, byte_idx_d;
    logic                  busy_q, busy_d;
    logic                  rd_en_q, rd_en_d;
    logic [COUNT_W-1:0]    words_sent_q, words_sent_d;

    logic                  go_c;
    logic                  byte_start_c;
    logic [DATA_BITS-1:0]  byte_data_c;
    logic                  byte_done_c;
    logic                  byte_tx;

    uart_tx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_tx_byte (
        .clk   (clk),
        .rst   (rst),
        .start (byte_start_c),
        .data  (byte_data_c),
        .done  (byte_done_c),
        .tx    (byte_tx)
    );

    // Word-level registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            word_q       <= '0;
            byte_idx_q   <= '0;
            busy_q       <= 1'b0;
            rd_en_q      <= 1'b0;
            words_sent_q <= '0;
        end else begin
            word_q       <= word_d;
            byte_idx_q   <= byte_idx_d;
            busy_q       <= busy_d;
            rd_en_q      <= rd_en_d;
            words_sent_q <= words_sent_d;
        end
    end

    // Word sequencing: pop and launch byte 0, then chain bytes 1..3.
    always_comb begin
        word_d       = word_q;
        byte_idx_d   = byte_idx_q;
        busy_d       = busy_q;
        rd_en_d      = 1'b0;
        words_sent_d = words_sent_q;
        byte_start_c = 1'b0;
        byte_data_c  = fifo_rd_data[DATA_BITS-1:0];
        go_c         = enable && !fifo_empty && !busy_q;

        if (go_c) begin
            // Byte 0 comes straight from the FIFO head; word_q loads in parallel.
            word_d       = fifo_rd_data;
            rd_en_d      = 1'b1;
            byte_idx_d   = '0;
            busy_d       = 1'b1;
            byte_start_c = 1'b1;
        end else if (busy_q && byte_done_c) begin
            if (byte_idx_q == BYTE_LAST) begin
                busy_d       = 1'b0;
                byte_idx_d   = '0;
                words_sent_d = words_sent_q + 1'b1;
            end else begin
                byte_idx_d   = byte_idx_q + 1'b1;
                byte_start_c = 1'b1;
                byte_data_c  = word_q[{byte_idx_d, 3'b000} +: DATA_BITS];
            end
        end
    end

    assign fifo_rd_en = rd_en_q;
    assign uart_tx    = byte_tx;
    assign busy       = busy_q;
    assign words_sent = words_sent_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Self-checking bench for fifo_uart_tx: FIFO model, UART line decoder and a
// byte/word-level reference model built from pushed words.
module tb_fifo_uart_tx;

    localparam int unsigned CLK_FREQ  = 1_000_000;
    localparam int unsigned BAUD      = 100_000;
    localparam int unsigned CPB       = CLK_FREQ / BAUD;
    localparam int unsigned WORD_CYC  = 40 * CPB;
    localparam int unsigned DEPTH     = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        fifo_empty;
    logic [31:0] fifo_rd_data;
    logic        fifo_rd_en;
    logic        uart_tx;
    logic        busy;
    logic [15:0] words_sent;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // FIFO model: initial block owns writes, the negedge monitor owns pops.
    logic [31:0] fifo_mem [DEPTH];
    int unsigned wr_ptr = 0;
    int unsigned rd_ptr = 0;
    assign fifo_empty   = (wr_ptr == rd_ptr);
    assign fifo_rd_data = fifo_mem[rd_ptr[4:0]];

    int unsigned pops = 0;
    int unsigned pop_on_empty = 0;
    int unsigned busy_cycles = 0;
    int unsigned cyc = 0;

    logic [7:0]  rx_q[$];
    int unsigned rx_start_q[$];
    int unsigned frame_err = 0;
    logic [7:0]  exp_q[$];
    int unsigned n_cmp = 0;
    int unsigned exp_words = 0;

    fifo_uart_tx #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .fifo_empty   (fifo_empty),
        .fifo_rd_data (fifo_rd_data),
        .fifo_rd_en   (fifo_rd_en),
        .uart_tx      (uart_tx),
        .busy         (busy),
        .words_sent   (words_sent)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pops, pop-while-empty and busy occupancy.
    always @(negedge clk) begin
        if (fifo_rd_en === 1'b1) begin
            pops <= pops + 1;
            if (wr_ptr == rd_ptr) pop_on_empty <= pop_on_empty + 1;
            else rd_ptr <= rd_ptr + 1;
        end
        if (busy === 1'b1) busy_cycles <= busy_cycles + 1;
    end

    // UART decoder: every bit must hold its level for all CPB samples.
    always begin : rx_mon
        logic [9:0]  bits;
        bit          ok;
        bit          aborted;
        int unsigned t0;
        @(negedge clk);
        if (rst === 1'b1 && uart_tx === 1'b0) begin
            t0 = cyc;
            ok = 1'b1;
            aborted = 1'b0;
            bits = '0;
            for (int j = 0; j < 10 && !aborted; j++) begin
                for (int c = 0; c < int'(CPB) && !aborted; c++) begin
                    if (j != 0 || c != 0) @(negedge clk);
                    if (rst !== 1'b1) aborted = 1'b1;
                    else if (c == 0) bits[j] = uart_tx;
                    else if (uart_tx !== bits[j]) ok = 1'b0;
                end
            end
            if (!aborted) begin
                rx_q.push_back(bits[8:1]);
                rx_start_q.push_back(t0);
                if (!ok || bits[0] != 1'b0 || bits[9] != 1'b1) frame_err = frame_err + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push_word(input logic [31:0] w);
        fifo_mem[wr_ptr[4:0]] = w;
        wr_ptr = wr_ptr + 1;
    endtask

    // Reference: a word goes out as its bytes, least significant first.
    task automatic expect_word(input logic [31:0] w, input int nbytes);
        for (int k = 0; k < nbytes; k++) exp_q.push_back(w[8*k +: 8]);
    endtask

    task automatic check_bytes(input string tag);
        check({tag, "_nbytes"}, 32'(rx_q.size()), 32'(exp_q.size()));
        for (int i = int'(n_cmp); i < exp_q.size() && i < rx_q.size(); i++)
            check({tag, "_byte"}, 32'(rx_q[i]), 32'(exp_q[i]));
        n_cmp = exp_q.size();
    endtask

    task automatic wait_idle(input int unsigned max_cyc);
        int unsigned n = 0;
        int unsigned quiet = 0;
        while (quiet < 3 && n < max_cyc) begin
            @(negedge clk);
            n++;
            if (busy === 1'b0) quiet++;
            else quiet = 0;
        end
        if (quiet < 3) check("idle_timeout", 32'(quiet), 32'd3);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int unsigned p0;
        int unsigned b0;
        int unsigned base;
        logic [31:0] w;

        // Reset holds everything quiet even with a word ready and enable high.
        rst = 1'b0;
        enable = 1'b1;
        push_word(32'hA5C3_0F81);
        repeat (20) begin
            @(negedge clk);
            check("rst_tx", 32'(uart_tx), 32'd1);
            check("rst_rd_en", 32'(fifo_rd_en), 32'd0);
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_words", 32'(words_sent), 32'd0);
        end
        check("rst_pops", pops, 32'd0);
        enable = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_pops", pops, 32'd0);

        // Single word with a one-cycle enable pulse.
        p0 = pops;
        b0 = busy_cycles;
        expect_word(32'hA5C3_0F81, 4);
        @(negedge clk); enable = 1'b1;
        @(negedge clk); enable = 1'b0;
        check("lat_rd_en", 32'(fifo_rd_en), 32'd1);
        check("lat_tx", 32'(uart_tx), 32'd0);
        check("lat_busy", 32'(busy), 32'd1);
        @(negedge clk);
        check("rd_en_one_cycle", 32'(fifo_rd_en), 32'd0);
        wait_idle(WORD_CYC + 100);
        check_bytes("single");
        check("single_pops", pops - p0, 32'd1);
        check("single_busy_cycles", busy_cycles - b0, WORD_CYC);
        exp_words++;
        check("single_words", 32'(words_sent), exp_words);

        // Back-to-back words.
        p0 = pops;
        base = rx_start_q.size();
        push_word(32'h0000_0001); expect_word(32'h0000_0001, 4);
        push_word(32'hFFFF_FFFF); expect_word(32'hFFFF_FFFF, 4);
        push_word(32'h1234_5678); expect_word(32'h1234_5678, 4);
        enable = 1'b1;
        wait_idle(3 * (WORD_CYC + 1) + 100);
        enable = 1'b0;
        check_bytes("b2b");
        check("b2b_pops", pops - p0, 32'd3);
        exp_words += 3;
        check("b2b_words", 32'(words_sent), exp_words);
        if (rx_start_q.size() >= base + 12) begin
            check("b2b_byte_gap", rx_start_q[base+1] - rx_start_q[base], 10 * CPB);
            check("b2b_word_gap1", rx_start_q[base+4] - rx_start_q[base], WORD_CYC + 1);
            check("b2b_word_gap2", rx_start_q[base+8] - rx_start_q[base+4], WORD_CYC + 1);
        end

        // Enable drops mid-word: the word finishes, the next is not popped.
        p0 = pops;
        w = $urandom;
        push_word(w);
        push_word(32'h5A00_3C7E);
        expect_word(w, 4);
        @(negedge clk); enable = 1'b1;
        repeat (50) @(negedge clk);
        enable = 1'b0;
        wait_idle(WORD_CYC + 100);
        repeat (20) @(negedge clk);
        check_bytes("drop");
        check("drop_pops", pops - p0, 32'd1);
        check("drop_busy", 32'(busy), 32'd0);
        check("drop_fifo_level", wr_ptr - rd_ptr, 32'd1);
        exp_words++;
        check("drop_words", 32'(words_sent), exp_words);

        // Reset during DATA of byte 2 (byte 2 is 0x00, so the line is low).
        p0 = pops;
        expect_word(32'h5A00_3C7E, 2);
        @(negedge clk); enable = 1'b1;
        @(negedge clk); enable = 1'b0;
        repeat (235) @(negedge clk);
        check("midrst_tx_before", 32'(uart_tx), 32'd0);
        #2 rst = 1'b0;
        #1;
        check("midrst_tx_async", 32'(uart_tx), 32'd1);
        check("midrst_busy_async", 32'(busy), 32'd0);
        check("midrst_words", 32'(words_sent), 32'd0);
        exp_words = 0;
        @(negedge clk);
        @(negedge clk); rst = 1'b1;
        repeat (5) @(negedge clk);
        check("midrst_idle_busy", 32'(busy), 32'd0);
        check("midrst_idle_tx", 32'(uart_tx), 32'd1);
        check("midrst_pops", pops - p0, 32'd1);
        check_bytes("midrst");

        // Counter wrap from 16'hFFFF.
        @(negedge clk); force dut.words_sent_q = 16'hFFFF;
        @(negedge clk); release dut.words_sent_q;
        @(negedge clk);
        check("wrap_preload", 32'(words_sent), 32'h0000_FFFF);
        w = $urandom;
        push_word(w);
        expect_word(w, 4);
        @(negedge clk); enable = 1'b1;
        @(negedge clk); enable = 1'b0;
        wait_idle(WORD_CYC + 100);
        check_bytes("wrap");
        check("wrap_words", 32'(words_sent), 32'd0);
        exp_words = 0;

        // Random words arriving at random times with enable held high.
        p0 = pops;
        enable = 1'b1;
        for (int i = 0; i < 6; i++) begin
            w = $urandom;
            push_word(w);
            expect_word(w, 4);
            exp_words++;
            repeat ($urandom_range(0, 450)) @(negedge clk);
        end
        wait_idle(6 * (WORD_CYC + 1) + 200);
        enable = 1'b0;
        check_bytes("rand");
        check("rand_pops", pops - p0, 32'd6);
        check("rand_words", 32'(words_sent), exp_words);
        check("rand_fifo_level", wr_ptr - rd_ptr, 32'd0);

        check("frame_errors", frame_err, 32'd0);
        check("pop_while_empty", pop_on_empty, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
